// File: rtl/mux_8x1_rr.sv
// Round-robin 8-to-1 valid/ready collector with a registered single-entry output.
// Each output word carries its 3-bit source lane index for a downstream demux.
module mux_8x1_rr #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*W-1:0] in_data,
  input  logic [7:0]     in_valid,
  output logic [7:0]     in_ready,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] cand;
  logic             grant_found;
  logic             load_en;
  logic [W-1:0]     lane_data [LANES];

  // Unpack the flat lane bus.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane_data[i] = in_data[i*W +: W];
    end
  end

  // Circular search from ptr; scanning downward leaves the nearest lane as the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load_en  = !rst && (!out_valid || out_ready);
  assign in_ready = (load_en && grant_found) ? (8'b1 << grant_idx) : 8'b0;

  // Output register and priority pointer; drain and reload share one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_found) begin
        out_data  <= lane_data[grant_idx];
        out_sel   <= grant_idx;
        out_valid <= 1'b1;
        ptr       <= grant_idx + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
